uni_bin_dec: RTL and testbench
==============================

// Module: uni_bin_dec
// PURPOSE
//   Decoder at the receiving end of the unipolar rate-coded bitstream link.
//   Counts ones over a fixed window of 2^DATAWD valid bits and returns the
//   binary magnitude, undoing the counter-compare encoders in the scu library.
//   Sits at the output of a stochastic datapath, feeding results back to the
//   binary domain through a valid/ready holding register.
// PARAMETERS
//   DATAWD  8  result width; window length = 2^DATAWD valid bits
//   CONT    1  1: windows run back-to-back after start; 0: stop after one window
// PORTS
//   clk      in   1       clock, rising edge
//   rst_n    in   1       asynchronous reset, active low
//   iStart   in   1       align/restart window; bit on this cycle is not counted
//   iEn      in   1       iBit is valid this cycle
//   iBit     in   1       unipolar stream bit
//   iReady   in   1       consumer accepts oData when oValid=1
//   oData    out  DATAWD  decoded magnitude (ones in window, saturated)
//   oValid   out  1       oData holds an unconsumed result
//   oBusy    out  1       state is ACC
//   oDrop    out  1       1-cycle pulse: unconsumed result was overwritten
// BEHAVIOUR
//   Reset: state IDLE; cntW, cntOnes, oData = 0; oValid, oBusy, oDrop = 0.
//   State IDLE: ignores iEn/iBit. iStart -> ACC with cntW=0, cntOnes=0.
//   State ACC (oBusy=1), per cycle, priority order:
//     - iStart: cntW=0, cntOnes=0, partial window discarded, no result.
//     - else iEn=1: cntW+=1 (DATAWD bits, wraps); cntOnes+=iBit.
//     - else: hold.
//   cntOnes is DATAWD+1 bits (0..2^DATAWD). Window ends on the iEn cycle
//     where cntW == 2^DATAWD-1. On that edge:
//       oData <= min(cntOnes+iBit, 2^DATAWD-1)  (all-ones window saturates);
//       oValid <= 1; cntW <= 0; cntOnes <= 0;
//       CONT=1: stay ACC, next window starts on the following valid bit;
//       CONT=0: go IDLE.
//   Latency: oValid rises the cycle after the last window bit is sampled.
//   Handshake: result transfers on a cycle with oValid & iReady; oValid
//     clears next edge unless a new result loads on that same edge (new
//     result wins, oValid stays 1, no drop). oData stable while oValid=1
//     and no new result loads. iReady is ignored while oValid=0.
//   Overrun: new result loading while oValid=1 and iReady=0 overwrites
//     oData and pulses oDrop for one cycle; oValid stays 1.
//   iStart in IDLE or ACC never touches oData/oValid.
//   Gaps in iEn stretch the window; only valid bits count toward 2^DATAWD.
//   Async reset mid-window: all state cleared immediately; no partial result.
//   Matches encoders that raise their stream on the cycle after load:
//     assert iStart together with the encoder load.
// TESTING  (DATAWD=8)
//   iStart, then 256 iEn bits: 64 ones then 192 zeros -> oValid 1 cycle after
//     bit 256, oData=64, oDrop=0.
//   iStart, 256 ones -> oData=255 (saturated); 256 zeros -> oData=0.
//   CONT=1, iReady=0, two full windows (100 then 30 ones) -> oData=30,
//     oDrop pulses once at second load; iReady=1 -> oValid clears next edge.
//   iStart after 100 valid bits (50 ones), then 256 bits with 10 ones ->
//     oData=10; no result emitted for the aborted window.
//   iEn toggling 1/0 each cycle, 128 ones in 256 valid bits -> oData=128
//     after 512 cycles; CONT=0 -> oBusy drops with oValid rise.
//   rst_n low at valid bit 200 -> all outputs 0 immediately; no oValid
//     until iStart plus 256 new valid bits.

Source files
------------

// File: rtl/uni_bin_dec_if.sv
// Valid/ready result bus and bitstream inputs of the unipolar rate-code decoder.
// The master drives the stream and iReady; the slave (decoder) returns the result.
interface uni_bin_dec_if #(parameter int DATAWD = 8);
    logic              iStart;
    logic              iEn;
    logic              iBit;
    logic              iReady;
    logic [DATAWD-1:0] oData;
    logic              oValid;
    logic              oBusy;
    logic              oDrop;

    modport master (output iStart, iEn, iBit, iReady,
                    input  oData, oValid, oBusy, oDrop);
    modport slave  (input  iStart, iEn, iBit, iReady,
                    output oData, oValid, oBusy, oDrop);
endinterface

// File: rtl/uni_bin_dec.sv
// Unipolar bitstream decoder: counts ones over 2^DATAWD valid bits and hands the
// saturated count to the binary domain through a valid/ready holding register.
module uni_bin_dec #(
    parameter int DATAWD = 8,
    parameter bit CONT   = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    uni_bin_dec_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [DATAWD-1:0] cnt_w_q, cnt_w_d;
    logic [DATAWD:0]   cnt_ones_q, cnt_ones_d;
    logic [DATAWD-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              drop_q, drop_d;
    logic              win_end;
    logic [DATAWD:0]   ones_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_w_q    <= '0;
            cnt_ones_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_w_q    <= cnt_w_d;
            cnt_ones_q <= cnt_ones_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
        end
    end

    // Count including the bit sampled on the closing edge; only a full
    // all-ones window can reach 2^DATAWD, which is clamped below.
    assign ones_sum = cnt_ones_q + (DATAWD+1)'(bus.iBit);
    assign win_end  = (state_q == ACC) && !bus.iStart && bus.iEn && (&cnt_w_q);

    always_comb begin
        state_d    = state_q;
        cnt_w_d    = cnt_w_q;
        cnt_ones_d = cnt_ones_q;
        case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    state_d    = ACC;
                    cnt_w_d    = '0;
                    cnt_ones_d = '0;
                end
            end
            ACC: begin
                if (bus.iStart) begin
                    cnt_w_d    = '0;
                    cnt_ones_d = '0;
                end else if (bus.iEn) begin
                    cnt_w_d    = cnt_w_q + 1'b1;
                    cnt_ones_d = win_end ? '0 : ones_sum;
                    if (win_end && !CONT) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A freshly loaded result beats a same-cycle consume; it only counts as a
    // drop when the previous result was still pending and not being taken.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q && !bus.iReady;
        drop_d  = 1'b0;
        if (win_end) begin
            data_d  = ones_sum[DATAWD] ? {DATAWD{1'b1}} : ones_sum[DATAWD-1:0];
            valid_d = 1'b1;
            drop_d  = valid_q && !bus.iReady;
        end
    end

    assign bus.oData  = data_q;
    assign bus.oValid = valid_q;
    assign bus.oBusy  = (state_q == ACC);
    assign bus.oDrop  = drop_q;
endmodule

// File: tb/tb_uni_bin_dec.sv
// Drives a continuous and a single-shot decoder with identical streams and checks
// both against a window-level reference model plus directed expected values.
module tb_uni_bin_dec;
    localparam int DATAWD = 8;
    localparam int WIN    = 1 << DATAWD;

    logic clk = 1'b0;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    uni_bin_dec_if #(.DATAWD(DATAWD)) bus1 ();
    uni_bin_dec_if #(.DATAWD(DATAWD)) bus0 ();

    uni_bin_dec #(.DATAWD(DATAWD), .CONT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    uni_bin_dec #(.DATAWD(DATAWD), .CONT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    typedef struct {
        bit busy;
        int nvalid;
        int ones;
        int data;
        bit valid;
        bit drop;
    } mdl_t;

    mdl_t m1, m0;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.busy = 0; r.nvalid = 0; r.ones = 0; r.data = 0; r.valid = 0; r.drop = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input bit cont,
                                      input bit st, input bit en, input bit b, input bit rdy);
        mdl_t n = s;
        int   r;
        n.drop = 0;
        if (s.valid && rdy) n.valid = 0;
        if (st) begin
            n.busy = 1; n.nvalid = 0; n.ones = 0;
        end else if (s.busy && en) begin
            if (s.nvalid + 1 == WIN) begin
                r = s.ones + b;
                if (r > WIN - 1) r = WIN - 1;
                n.drop   = s.valid && !rdy;
                n.data   = r;
                n.valid  = 1;
                n.nvalid = 0;
                n.ones   = 0;
                if (!cont) n.busy = 0;
            end else begin
                n.nvalid = s.nvalid + 1;
                n.ones   = s.ones + b;
            end
        end
        return n;
    endfunction

    function automatic logic [DATAWD+2:0] pack(input mdl_t m);
        logic [31:0] d = m.data;
        return {d[DATAWD-1:0], m.valid, m.busy, m.drop};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, "/cont1"}, 32'({bus1.oData, bus1.oValid, bus1.oBusy, bus1.oDrop}), 32'(pack(m1)));
        chk({tag, "/cont0"}, 32'({bus0.oData, bus0.oValid, bus0.oBusy, bus0.oDrop}), 32'(pack(m0)));
    endtask

    task automatic cyc(input bit st, input bit en, input bit b, input bit rdy);
        bus1.iStart = st; bus1.iEn = en; bus1.iBit = b; bus1.iReady = rdy;
        bus0.iStart = st; bus0.iEn = en; bus0.iBit = b; bus0.iReady = rdy;
        @(posedge clk);
        m1 = mdl_step(m1, 1'b1, st, en, b, rdy);
        m0 = mdl_step(m0, 1'b0, st, en, b, rdy);
        @(negedge clk);
        cmp_all("cycle");
    endtask

    // n valid bits back to back: the first `ones` are 1, the rest 0
    task automatic bits(input int n, input int ones, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, i < ones, rdy);
    endtask

    initial begin
        int vb;
        m1 = mdl_reset(); m0 = mdl_reset();
        rst_n = 1'b0;
        bus1.iStart = 0; bus1.iEn = 0; bus1.iBit = 0; bus1.iReady = 0;
        bus0.iStart = 0; bus0.iEn = 0; bus0.iBit = 0; bus0.iReady = 0;
        #1;
        cmp_all("reset");
        chk("reset_out1", 32'({bus1.oData, bus1.oValid, bus1.oBusy, bus1.oDrop}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 64 ones then 192 zeros; result appears right after the last bit
        cyc(1, 0, 0, 0);
        bits(255, 64, 0);
        chk("lat_before", 32'(bus1.oValid), 32'd0);
        bits(1, 0, 0);
        chk("win64_data", 32'(bus1.oData), 32'd64);
        chk("win64_valid", 32'(bus1.oValid), 32'd1);
        chk("win64_drop", 32'(bus1.oDrop), 32'd0);
        chk("win64_busy1", 32'(bus1.oBusy), 32'd1);
        chk("win64_busy0", 32'(bus0.oBusy), 32'd0);
        cyc(0, 0, 0, 1);
        chk("consume", 32'(bus1.oValid), 32'd0);

        // saturating all-ones window, then all-zeros window
        cyc(1, 0, 0, 0);
        bits(WIN, WIN, 0);
        chk("sat_data", 32'(bus1.oData), 32'd255);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        bits(WIN, 0, 0);
        chk("zero_data", 32'(bus0.oData), 32'd0);
        chk("zero_valid", 32'(bus0.oValid), 32'd1);
        cyc(0, 0, 0, 1);

        // two back-to-back windows without consuming: overrun on the second
        cyc(1, 0, 0, 0);
        bits(WIN, 100, 0);
        chk("ovr_first", 32'(bus1.oData), 32'd100);
        bits(WIN, 30, 0);
        chk("ovr_data", 32'(bus1.oData), 32'd30);
        chk("ovr_drop", 32'(bus1.oDrop), 32'd1);
        chk("ovr_keep0", 32'(bus0.oData), 32'd100);
        cyc(0, 0, 0, 1);
        chk("ovr_drop_end", 32'(bus1.oDrop), 32'd0);
        chk("ovr_clear", 32'(bus1.oValid), 32'd0);

        // restart mid-window discards the partial count
        cyc(1, 0, 0, 0);
        bits(100, 50, 0);
        cyc(1, 0, 0, 0);
        bits(WIN, 10, 0);
        chk("abort_data", 32'(bus1.oData), 32'd10);
        cyc(0, 0, 0, 1);

        // iEn toggling: window stretches over 512 cycles
        cyc(1, 0, 0, 0);
        vb = 0;
        for (int i = 0; i < 2 * WIN; i++) begin
            if (i % 2 == 0) begin
                cyc(0, 1, vb < 128, 0);
                vb++;
            end else cyc(0, 0, 1, 0);
        end
        chk("gap_data", 32'(bus1.oData), 32'd128);
        chk("gap_valid0", 32'(bus0.oValid), 32'd1);
        chk("gap_busy0", 32'(bus0.oBusy), 32'd0);

        // async reset at valid bit 200 clears everything at once
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        bits(200, 120, 0);
        rst_n = 1'b0;
        #1;
        m1 = mdl_reset(); m0 = mdl_reset();
        cmp_all("async_rst");
        chk("rst_out0", 32'({bus0.oData, bus0.oValid, bus0.oBusy, bus0.oDrop}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bits(60, 60, 0);
        chk("post_rst_idle", 32'(bus1.oValid), 32'd0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < WIN; i++) cyc(0, 1, 1'($urandom_range(1)), 0);
        chk("post_rst_valid", 32'(bus1.oValid), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(299) == 0, $urandom_range(3) != 0,
                $urandom_range(7) < (i / 500), $urandom_range(3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
